// File: rtl/alu_fault_monitor.sv
// alu_fault_monitor
//
// Sequential checker placed directly downstream of the dual-ALU XOR comparator.
// On each sample event it classifies the redundant ALU pair as OK, SUSPECT or
// FAULT. It also keeps registered, sticky diagnostic state for the rest of the
// design.
//
// Parameters
//   WIDTH        width of the mismatch vector x (equals ALU data width)
//   FAULT_THRESH consecutive mismatching samples needed to enter FAULT (1..255)
//   CNT_W        width of the saturating total error counter
//
// Ports
//   clk           system clock, all state on rising edge
//   rst           asynchronous, active-high reset
//   sample_valid  x/y are valid this cycle
//   x             per-bit ALU result mismatch from the comparator
//   y             carry mismatch from the comparator
//   clear         synchronous clear of all status and sticky state (beats a sample)
//   mismatch      last sample had x!=0 or y=1
//   carry_err     y of the last sample
//   syndrome      x of the most recent mismatching sample
//   err_mask      sticky OR of all sampled x since reset/clear
//   err_count     total mismatching samples, saturating
//   consec_count  current run of consecutive mismatching samples, saturating at 255
//   state         00 OK, 01 SUSPECT, 10 FAULT
//   fault         high while state is FAULT
module alu_fault_monitor #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned FAULT_THRESH = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] x,
  input  logic             y,
  input  logic             clear,
  output logic             mismatch,
  output logic             carry_err,
  output logic [WIDTH-1:0] syndrome,
  output logic [WIDTH-1:0] err_mask,
  output logic [CNT_W-1:0] err_count,
  output logic [7:0]       consec_count,
  output logic [1:0]       state,
  output logic             fault
);

  typedef enum logic [1:0] {
    StOk      = 2'b00,
    StSuspect = 2'b01,
    StFault   = 2'b10
  } state_e;

  // Threshold widened by one bit so that a run of 255 plus the incoming sample
  // still compares correctly.
  localparam logic [8:0]       ThreshW = 9'(FAULT_THRESH);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
  localparam logic [7:0]       RunMax  = 8'hff;

  state_e           state_q, state_d;
  logic             mismatch_q, mismatch_d;
  logic             carry_err_q, carry_err_d;
  logic [WIDTH-1:0] syndrome_q, syndrome_d;
  logic [WIDTH-1:0] err_mask_q, err_mask_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [7:0]       consec_q, consec_d;

  logic       sample_ev;
  logic       bad;
  logic [8:0] run_len;
  logic       thresh_hit;

  assign sample_ev  = sample_valid & ~clear;
  assign bad        = (|x) | y;
  // Length of the run including the sample being taken now.
  assign run_len    = {1'b0, consec_q} + 9'd1;
  assign thresh_hit = (run_len >= ThreshW);

  // Datapath next-state
  always_comb begin
    mismatch_d  = mismatch_q;
    carry_err_d = carry_err_q;
    syndrome_d  = syndrome_q;
    err_mask_d  = err_mask_q;
    err_count_d = err_count_q;
    consec_d    = consec_q;

    if (clear) begin
      mismatch_d  = 1'b0;
      carry_err_d = 1'b0;
      syndrome_d  = '0;
      err_mask_d  = '0;
      err_count_d = '0;
      consec_d    = '0;
    end else if (sample_ev) begin
      mismatch_d  = bad;
      carry_err_d = y;
      err_mask_d  = err_mask_q | x;
      if (bad) begin
        // x may be all zero here when only the carry disagreed.
        syndrome_d = x;
        if (err_count_q != CntMax) begin
          err_count_d = err_count_q + 1'b1;
        end
        if (consec_q != RunMax) begin
          consec_d = consec_q + 8'd1;
        end
      end else begin
        consec_d = '0;
      end
    end
  end

  // Classification FSM next-state
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StOk;
    end else begin
      unique case (state_q)
        StOk: begin
          if (sample_ev && bad) begin
            state_d = thresh_hit ? StFault : StSuspect;
          end
        end
        StSuspect: begin
          if (sample_ev) begin
            if (bad) begin
              state_d = thresh_hit ? StFault : StSuspect;
            end else begin
              state_d = StOk;
            end
          end
        end
        // Absorbing: only clear or rst leave FAULT.
        StFault: state_d = StFault;
        // Encoding 11 is unreachable; recover to OK.
        default: state_d = StOk;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StOk;
      mismatch_q  <= 1'b0;
      carry_err_q <= 1'b0;
      syndrome_q  <= '0;
      err_mask_q  <= '0;
      err_count_q <= '0;
      consec_q    <= '0;
    end else begin
      state_q     <= state_d;
      mismatch_q  <= mismatch_d;
      carry_err_q <= carry_err_d;
      syndrome_q  <= syndrome_d;
      err_mask_q  <= err_mask_d;
      err_count_q <= err_count_d;
      consec_q    <= consec_d;
    end
  end

  assign mismatch     = mismatch_q;
  assign carry_err    = carry_err_q;
  assign syndrome     = syndrome_q;
  assign err_mask     = err_mask_q;
  assign err_count    = err_count_q;
  assign consec_count = consec_q;
  assign state        = state_q;
  // Decoded straight from the state register so it never lags state.
  assign fault        = (state_q == StFault);

endmodule

// File: tb/tb_alu_fault_monitor.sv
// Directed-vector bench for alu_fault_monitor. Two instances share the same
// stimulus: one with default parameters, one with CNT_W=4 to reach counter
// saturation quickly.
module tb_alu_fault_monitor;

  logic       clk;
  logic       rst;
  logic       sample_valid;
  logic [7:0] x;
  logic       y;
  logic       clear;

  logic        mismatch, carry_err, fault;
  logic [7:0]  syndrome, err_mask, consec_count;
  logic [15:0] err_count;
  logic [1:0]  state;

  logic        s_mismatch, s_carry_err, s_fault;
  logic [7:0]  s_syndrome, s_err_mask, s_consec_count;
  logic [3:0]  s_err_count;
  logic [1:0]  s_state;

  int n_vec;
  int n_err;

  alu_fault_monitor #(
    .WIDTH       (8),
    .FAULT_THRESH(3),
    .CNT_W       (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .x           (x),
    .y           (y),
    .clear       (clear),
    .mismatch    (mismatch),
    .carry_err   (carry_err),
    .syndrome    (syndrome),
    .err_mask    (err_mask),
    .err_count   (err_count),
    .consec_count(consec_count),
    .state       (state),
    .fault       (fault)
  );

  alu_fault_monitor #(
    .WIDTH       (8),
    .FAULT_THRESH(3),
    .CNT_W       (4)
  ) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .x           (x),
    .y           (y),
    .clear       (clear),
    .mismatch    (s_mismatch),
    .carry_err   (s_carry_err),
    .syndrome    (s_syndrome),
    .err_mask    (s_err_mask),
    .err_count   (s_err_count),
    .consec_count(s_consec_count),
    .state       (s_state),
    .fault       (s_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present one cycle of inputs, let the edge capture them, then sample
  // outputs just after the edge and return inputs to idle.
  task automatic apply(input logic v, input logic [7:0] xv, input logic yv, input logic clr);
    @(negedge clk);
    sample_valid = v;
    x            = xv;
    y            = yv;
    clear        = clr;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    x            = 8'h00;
    y            = 1'b0;
    clear        = 1'b0;
  endtask

  task automatic check_zero(input string pfx);
    check_eq({pfx, ".state"},     32'(state),        32'h0);
    check_eq({pfx, ".fault"},     32'(fault),        32'h0);
    check_eq({pfx, ".mismatch"},  32'(mismatch),     32'h0);
    check_eq({pfx, ".carry_err"}, 32'(carry_err),    32'h0);
    check_eq({pfx, ".syndrome"},  32'(syndrome),     32'h0);
    check_eq({pfx, ".err_mask"},  32'(err_mask),     32'h0);
    check_eq({pfx, ".err_count"}, 32'(err_count),    32'h0);
    check_eq({pfx, ".consec"},    32'(consec_count), 32'h0);
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst          = 1'b1;
    sample_valid = 1'b0;
    x            = 8'h00;
    y            = 1'b0;
    clear        = 1'b0;

    // Reset state
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Clean samples stay OK
    for (int i = 0; i < 4; i++) apply(1'b1, 8'h00, 1'b0, 1'b0);
    check_zero("clean");

    // OK -> SUSPECT -> SUSPECT -> OK -> SUSPECT
    apply(1'b1, 8'h04, 1'b0, 1'b0);
    check_eq("t2.s1.state", 32'(state), 32'h1);
    apply(1'b1, 8'h04, 1'b0, 1'b0);
    check_eq("t2.s2.state",  32'(state),        32'h1);
    check_eq("t2.s2.consec", 32'(consec_count), 32'd2);
    apply(1'b1, 8'h00, 1'b0, 1'b0);
    check_eq("t2.s3.state",  32'(state),        32'h0);
    check_eq("t2.s3.consec", 32'(consec_count), 32'd0);
    apply(1'b1, 8'h10, 1'b0, 1'b0);
    check_eq("t2.s4.state",     32'(state),        32'h1);
    check_eq("t2.s4.err_count", 32'(err_count),    32'd3);
    check_eq("t2.s4.err_mask",  32'(err_mask),     32'h14);
    check_eq("t2.s4.syndrome",  32'(syndrome),     32'h10);
    check_eq("t2.s4.consec",    32'(consec_count), 32'd1);
    check_eq("t2.s4.mismatch",  32'(mismatch),     32'h1);

    // Back-to-back bad samples, including a carry-only one, reach FAULT
    apply(1'b0, 8'h00, 1'b0, 1'b1);
    check_zero("t3.clear");
    apply(1'b1, 8'h01, 1'b0, 1'b0);
    check_eq("t3.s1.carry", 32'(carry_err), 32'h0);
    check_eq("t3.s1.state", 32'(state),     32'h1);
    apply(1'b1, 8'h00, 1'b1, 1'b0);
    check_eq("t3.s2.carry",    32'(carry_err), 32'h1);
    check_eq("t3.s2.syndrome", 32'(syndrome),  32'h00);
    check_eq("t3.s2.mismatch", 32'(mismatch),  32'h1);
    check_eq("t3.s2.fault",    32'(fault),     32'h0);
    apply(1'b1, 8'h80, 1'b0, 1'b0);
    check_eq("t3.s3.carry",    32'(carry_err), 32'h0);
    check_eq("t3.s3.fault",    32'(fault),     32'h1);
    check_eq("t3.s3.state",    32'(state),     32'h2);
    check_eq("t3.s3.syndrome", 32'(syndrome),  32'h80);
    check_eq("t3.s3.err_mask", 32'(err_mask),  32'h81);
    apply(1'b1, 8'h00, 1'b0, 1'b0);
    apply(1'b1, 8'h00, 1'b0, 1'b0);
    check_eq("t3.good.state",     32'(state),        32'h2);
    check_eq("t3.good.fault",     32'(fault),        32'h1);
    check_eq("t3.good.mismatch",  32'(mismatch),     32'h0);
    check_eq("t3.good.consec",    32'(consec_count), 32'd0);
    check_eq("t3.good.err_count", 32'(err_count),    32'd3);
    check_eq("t3.good.syndrome",  32'(syndrome),     32'h80);

    // Idle gaps (with junk on x/y) do not break a run
    apply(1'b0, 8'h00, 1'b0, 1'b1);
    apply(1'b1, 8'h02, 1'b0, 1'b0);
    check_eq("t4.s1.state", 32'(state), 32'h1);
    for (int i = 0; i < 5; i++) apply(1'b0, 8'hff, 1'b1, 1'b0);
    check_eq("t4.idle.state",    32'(state),        32'h1);
    check_eq("t4.idle.consec",   32'(consec_count), 32'd1);
    check_eq("t4.idle.err_mask", 32'(err_mask),     32'h02);
    check_eq("t4.idle.syndrome", 32'(syndrome),     32'h02);
    check_eq("t4.idle.carry",    32'(carry_err),    32'h0);
    check_eq("t4.idle.count",    32'(err_count),    32'd1);
    apply(1'b1, 8'h02, 1'b0, 1'b0);
    check_eq("t4.s2.state", 32'(state), 32'h1);
    apply(1'b1, 8'h00, 1'b1, 1'b0);
    check_eq("t4.s3.consec", 32'(consec_count), 32'd3);
    check_eq("t4.s3.state",  32'(state),        32'h2);
    check_eq("t4.s3.fault",  32'(fault),        32'h1);
    check_eq("t4.s3.count",  32'(err_count),    32'd3);

    // Clear beats a simultaneous sample
    apply(1'b1, 8'hff, 1'b0, 1'b1);
    check_zero("t5.clear");

    // Saturation on the CNT_W=4 instance
    for (int i = 0; i < 20; i++) apply(1'b1, 8'h01, 1'b0, 1'b0);
    check_eq("t6.sat.err_count", 32'(s_err_count),    32'd15);
    check_eq("t6.sat.consec",    32'(s_consec_count), 32'd20);
    check_eq("t6.sat.state",     32'(s_state),        32'h2);
    check_eq("t6.main.err_count", 32'(err_count),     32'd20);

    // Asynchronous reset mid-cycle takes effect before the next edge
    #2;
    rst = 1'b1;
    #1;
    check_zero("t6.arst");
    check_eq("t6.arst.sat.count",  32'(s_err_count),    32'd0);
    check_eq("t6.arst.sat.consec", 32'(s_consec_count), 32'd0);
    check_eq("t6.arst.sat.fault",  32'(s_fault),        32'h0);
    check_eq("t6.arst.sat.mask",   32'(s_err_mask),     32'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
